// File: rtl/tick_seq_pkg.sv
// Shared constants and state encoding for the tick sequencer and its divider.
package tick_seq_pkg;

    localparam int unsigned DEF_DIV_W   = 32;
    localparam int unsigned DEF_VAL_W   = 4;

    localparam int unsigned DEF_PERIOD0 = 1;
    localparam int unsigned DEF_PERIOD1 = 50000000;
    localparam int unsigned DEF_PERIOD2 = 100000000;
    localparam int unsigned DEF_PERIOD3 = 200000000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/tick_sequencer_div_core.sv
// Loadable down-counter with a registered zero flag; load wins over enable.
module div_core #(
    parameter int unsigned DIV_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [DIV_W-1:0] count;

    // zero is kept in step with count so the sequencer sees it without a compare delay
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
            zero  <= 1'b1;
        end else if (load) begin
            count <= load_val;
            zero  <= (load_val == '0);
        end else if (en && !zero) begin
            count <= count - DIV_W'(1);
            zero  <= (count == DIV_W'(1));
        end
    end

endmodule

// File: rtl/tick_sequencer.sv
// Run/pause/step controller for the rate divider and the display counter.
module tick_sequencer
    import tick_seq_pkg::*;
#(
    parameter int unsigned PERIOD0 = DEF_PERIOD0,
    parameter int unsigned PERIOD1 = DEF_PERIOD1,
    parameter int unsigned PERIOD2 = DEF_PERIOD2,
    parameter int unsigned PERIOD3 = DEF_PERIOD3,
    parameter int unsigned DIV_W   = DEF_DIV_W,
    parameter int unsigned VAL_W   = DEF_VAL_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             pause,
    input  logic             step,
    input  logic [1:0]       rate_sel,
    input  logic             up,
    input  logic             wrap_en,
    input  logic [VAL_W-1:0] limit,
    output logic [VAL_W-1:0] value,
    output logic             tick,
    output logic [1:0]       state,
    output logic             done
);

    state_t           state_q;
    logic             up_q;
    logic [VAL_W-1:0] limit_q;

    logic             div_zero;
    logic             div_load;
    logic             div_en;
    logic [DIV_W-1:0] div_load_val;

    logic [VAL_W-1:0] start_home_c;
    logic [VAL_W-1:0] start_term_c;
    logic [VAL_W-1:0] home_c;
    logic [VAL_W-1:0] term_c;
    logic [VAL_W-1:0] adv_val_c;
    logic             adv_done_c;
    logic             adv_stop_c;
    logic             run_tick_c;

    function automatic logic [DIV_W-1:0] period_of(input logic [1:0] sel);
        logic [DIV_W-1:0] p;
        case (sel)
            2'd0:    p = DIV_W'(PERIOD0);
            2'd1:    p = DIV_W'(PERIOD1);
            2'd2:    p = DIV_W'(PERIOD2);
            default: p = DIV_W'(PERIOD3);
        endcase
        return p;
    endfunction

    // Divider is reloaded at start and at every RUN tick from the live rate_sel
    always_comb begin
        run_tick_c   = (state_q == ST_RUN) && !pause && div_zero;
        div_load     = start || run_tick_c;
        div_en       = !start && (state_q == ST_RUN) && !pause && !div_zero;
        div_load_val = period_of(rate_sel) - DIV_W'(1);
    end

    div_core #(
        .DIV_W (DIV_W)
    ) u_div_core (
        .clock    (clock),
        .reset    (reset),
        .load     (div_load),
        .load_val (div_load_val),
        .en       (div_en),
        .zero     (div_zero)
    );

    // Next display value for a tick or step, plus terminal/stop decisions
    always_comb begin
        start_home_c = up ? '0 : limit;
        start_term_c = up ? limit : '0;
        home_c       = up_q ? '0 : limit_q;
        term_c       = up_q ? limit_q : '0;
        adv_val_c    = up_q ? (value + VAL_W'(1)) : (value - VAL_W'(1));
        adv_done_c   = 1'b0;
        adv_stop_c   = 1'b0;
        if ((value == term_c) && wrap_en) begin
            adv_val_c  = home_c;
            adv_done_c = (home_c == term_c);
        end else begin
            adv_done_c = (adv_val_c == term_c);
            adv_stop_c = adv_done_c && !wrap_en;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            value   <= '0;
            tick    <= 1'b0;
            done    <= 1'b0;
            up_q    <= 1'b0;
            limit_q <= '0;
        end else begin
            tick <= 1'b0;
            done <= 1'b0;
            if (start) begin
                up_q    <= up;
                limit_q <= limit;
                value   <= start_home_c;
                // Already terminal with no wrap: nothing to count, report done at once
                if ((start_home_c == start_term_c) && !wrap_en) begin
                    state_q <= ST_DONE;
                    done    <= 1'b1;
                end else begin
                    state_q <= ST_RUN;
                end
            end else begin
                case (state_q)
                    ST_RUN: begin
                        if (pause) begin
                            state_q <= ST_PAUSED;
                        end else if (div_zero) begin
                            value <= adv_val_c;
                            tick  <= 1'b1;
                            done  <= adv_done_c;
                            if (adv_stop_c) state_q <= ST_DONE;
                        end
                    end
                    ST_PAUSED: begin
                        if (pause) begin
                            state_q <= ST_RUN;
                        end else if (step) begin
                            value <= adv_val_c;
                            tick  <= 1'b1;
                            done  <= adv_done_c;
                            if (adv_stop_c) state_q <= ST_DONE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_tick_sequencer.sv
// Directed bench for tick_sequencer with short divider periods.
module tb_tick_sequencer;

    localparam int unsigned VW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          pause;
    logic          step;
    logic [1:0]    rate_sel;
    logic          up;
    logic          wrap_en;
    logic [VW-1:0] limit;
    logic [VW-1:0] value;
    logic          tick;
    logic [1:0]    state;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    tick_sequencer #(
        .PERIOD0 (1),
        .PERIOD1 (4),
        .PERIOD2 (8),
        .PERIOD3 (16),
        .DIV_W   (32),
        .VAL_W   (VW)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .pause    (pause),
        .step     (step),
        .rate_sel (rate_sel),
        .up       (up),
        .wrap_en  (wrap_en),
        .limit    (limit),
        .value    (value),
        .tick     (tick),
        .state    (state),
        .done     (done)
    );

    assert property (@(negedge clock) done |-> (tick || state == 2'd3));
    assert property (@(negedge clock) tick |-> (state != 2'd0));

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic wait_tick(input int budget, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!tick && n < budget);
    endtask

    task automatic do_start(input logic [1:0] rs, input logic u, input logic [VW-1:0] lim,
                            input logic w);
        rate_sel = rs;
        up       = u;
        limit    = lim;
        wrap_en  = w;
        start    = 1'b1;
        cycle();
        start    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int n;
        int cnt;
        logic [VW-1:0] exp_val [5];
        logic          exp_dn  [5];

        reset = 1'b1; start = 1'b0; pause = 1'b0; step = 1'b0;
        rate_sel = 2'd0; up = 1'b1; wrap_en = 1'b0; limit = '0;
        @(negedge clock);
        cycle();
        cycle();
        check_eq("rst_value", value, 0);
        check_eq("rst_state", state, 0);
        check_eq("rst_tick", tick, 0);
        check_eq("rst_done", done, 0);
        reset = 1'b0;
        cycle();
        check_eq("idle_hold", state, 0);

        // up, limit 3, wrap, period 4
        exp_val = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd1};
        exp_dn  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        do_start(2'd1, 1'b1, 4'd3, 1'b1);
        check_eq("up_start_state", state, 1);
        check_eq("up_start_value", value, 0);
        for (int i = 0; i < 5; i++) begin
            wait_tick(40, n);
            check_eq("up_interval", n, 4);
            check_eq("up_value", value, exp_val[i]);
            check_eq("up_done", done, exp_dn[i]);
        end

        // down, limit 2, no wrap, period 1
        do_start(2'd0, 1'b0, 4'd2, 1'b0);
        check_eq("dn_start_value", value, 2);
        check_eq("dn_start_state", state, 1);
        cycle();
        check_eq("dn_v1", value, 1);
        check_eq("dn_t1", tick, 1);
        check_eq("dn_d1", done, 0);
        cycle();
        check_eq("dn_v0", value, 0);
        check_eq("dn_t0", tick, 1);
        check_eq("dn_d0", done, 1);
        check_eq("dn_state_done", state, 3);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (tick || done) cnt++;
        end
        check_eq("dn_quiet_ticks", cnt, 0);
        check_eq("dn_hold_value", value, 0);
        check_eq("dn_hold_state", state, 3);

        // pause / step / resume at period 4
        do_start(2'd1, 1'b1, 4'd15, 1'b1);
        wait_tick(40, n);
        check_eq("ps_first_int", n, 4);
        check_eq("ps_first_val", value, 1);
        cycle();
        cycle();
        pause = 1'b1;
        cycle();
        pause = 1'b0;
        check_eq("ps_paused", state, 2);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (tick) cnt++;
        end
        check_eq("ps_no_ticks", cnt, 0);
        check_eq("ps_frozen_val", value, 1);
        step = 1'b1;
        cycle();
        step = 1'b0;
        check_eq("ps_step1_tick", tick, 1);
        check_eq("ps_step1_val", value, 2);
        check_eq("ps_step1_state", state, 2);
        cycle();
        check_eq("ps_step1_pulse", tick, 0);
        step = 1'b1;
        cycle();
        step = 1'b0;
        check_eq("ps_step2_tick", tick, 1);
        check_eq("ps_step2_val", value, 3);
        // pause and step together: pause wins
        pause = 1'b1;
        step  = 1'b1;
        cycle();
        pause = 1'b0;
        step  = 1'b0;
        check_eq("ps_resume_state", state, 1);
        check_eq("ps_resume_notick", tick, 0);
        check_eq("ps_resume_val", value, 3);
        wait_tick(40, n);
        check_eq("ps_resume_int", n, 2);
        check_eq("ps_resume_tickval", value, 4);

        // rate change mid-interval takes effect at the next tick boundary
        do_start(2'd2, 1'b1, 4'd15, 1'b1);
        wait_tick(40, n);
        check_eq("rt_int0", n, 8);
        cycle();
        cycle();
        rate_sel = 2'd3;
        wait_tick(40, n);
        check_eq("rt_int1", n + 2, 8);
        wait_tick(40, n);
        check_eq("rt_int2", n, 16);
        wait_tick(40, n);
        check_eq("rt_int3", n, 16);
        check_eq("rt_value", value, 4);

        // degenerate: start value equals terminal
        do_start(2'd0, 1'b1, 4'd0, 1'b0);
        check_eq("dg_state", state, 3);
        check_eq("dg_done", done, 1);
        check_eq("dg_tick", tick, 0);
        check_eq("dg_value", value, 0);
        cycle();
        check_eq("dg_done_once", done, 0);
        check_eq("dg_state_hold", state, 3);
        do_start(2'd0, 1'b1, 4'd0, 1'b1);
        check_eq("dgw_state", state, 1);
        check_eq("dgw_done0", done, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_eq("dgw_tick", tick, 1);
            check_eq("dgw_done", done, 1);
            check_eq("dgw_value", value, 0);
        end

        // reset beats a simultaneous start mid-run
        do_start(2'd0, 1'b1, 4'd15, 1'b1);
        cycle();
        cycle();
        check_eq("rs_pre_value", value, 2);
        reset = 1'b1;
        start = 1'b1;
        cycle();
        reset = 1'b0;
        start = 1'b0;
        check_eq("rs_value", value, 0);
        check_eq("rs_state", state, 0);
        check_eq("rs_tick", tick, 0);
        check_eq("rs_done", done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
